// File: rtl/cache_bank_param.sv
// Parametrised write-back, write-allocate set-associative cache bank with true-LRU
// replacement, single outstanding miss, bulk invalidate and hit/miss counters.
module cache_bank_param #(
   parameter int WAYS       = 4,
   parameter int SETS       = 4,
   parameter int LINE_BYTES = 16,
   parameter int PADDR_W    = 15,
   parameter int ID_W       = 7
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [PADDR_W-1:0]      req_pAddress,
   input  logic                    req_w,
   input  logic [8*LINE_BYTES-1:0] req_data,
   input  logic [LINE_BYTES-1:0]   req_mask,
   input  logic [ID_W-1:0]         req_id,
   input  logic                    inv_all,
   output logic                    resp_valid,
   output logic [8*LINE_BYTES-1:0] resp_data,
   output logic [ID_W-1:0]         resp_id,
   output logic                    resp_hit,
   output logic                    mem_wb_valid,
   input  logic                    mem_wb_ready,
   output logic [PADDR_W-1:0]      mem_wb_addr,
   output logic [8*LINE_BYTES-1:0] mem_wb_data,
   output logic                    mem_rd_valid,
   input  logic                    mem_rd_ready,
   output logic [PADDR_W-1:0]      mem_rd_addr,
   input  logic                    fill_valid,
   input  logic [8*LINE_BYTES-1:0] fill_data,
   output logic [15:0]             hit_cnt,
   output logic [15:0]             miss_cnt
);

   localparam int OFF_W  = $clog2(LINE_BYTES);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = PADDR_W - OFF_W - IDX_W;
   localparam int WAY_W  = $clog2(WAYS);
   localparam int LINE_W = 8 * LINE_BYTES;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WB   = 3'd1;
   localparam logic [2:0] S_RD   = 3'd2;
   localparam logic [2:0] S_FILL = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   logic [2:0]                  state;
   logic [SETS-1:0][WAYS-1:0]   valid;
   logic [SETS-1:0][WAYS-1:0]   dirty;
   logic [WAY_W-1:0]            age      [SETS][WAYS];
   logic [TAG_W-1:0]            tag_mem  [SETS][WAYS];
   logic [LINE_W-1:0]           data_mem [SETS][WAYS];
   logic                        inv_pend;

   // latched miss context
   logic [IDX_W-1:0]            l_idx;
   logic [TAG_W-1:0]            l_tag;
   logic [WAY_W-1:0]            l_way;
   logic                        l_w;
   logic [LINE_W-1:0]           l_data;
   logic [LINE_BYTES-1:0]       l_mask;
   logic [ID_W-1:0]             l_id;

   logic [IDX_W-1:0]            in_idx;
   logic [TAG_W-1:0]            in_tag;
   logic                        unused_off;
   logic                        hit;
   logic [WAY_W-1:0]            hit_way;
   logic [WAY_W-1:0]            vic_way;
   logic                        found_inv;
   logic                        accept;
   logic                        hit_acc;
   logic                        fill_acc;
   logic [LINE_W-1:0]           hit_line;
   logic [LINE_W-1:0]           hit_merged;
   logic [LINE_W-1:0]           fill_line;
   logic                        lru_en;
   logic [IDX_W-1:0]            lru_set;
   logic [WAY_W-1:0]            lru_way;

   function automatic logic [LINE_W-1:0] merge(input logic [LINE_W-1:0] base,
                                                input logic [LINE_W-1:0] wdata,
                                                input logic [LINE_BYTES-1:0] m);
      logic [LINE_W-1:0] r;
      r = base;
      for (int b = 0; b < LINE_BYTES; b++)
         if (m[b]) r[8*b +: 8] = wdata[8*b +: 8];
      return r;
   endfunction

   assign in_idx     = req_pAddress[OFF_W+IDX_W-1:OFF_W];
   assign in_tag     = req_pAddress[PADDR_W-1:OFF_W+IDX_W];
   assign unused_off = ^req_pAddress[OFF_W-1:0];

   assign req_ready    = (state == S_IDLE) && !inv_all && !inv_pend;
   assign mem_wb_valid = (state == S_WB);
   assign mem_rd_valid = (state == S_RD);

   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      found_inv = 1'b0;
      vic_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!hit && valid[in_idx][w] && tag_mem[in_idx][w] == in_tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!found_inv && !valid[in_idx][w]) begin
            found_inv = 1'b1;
            vic_way   = WAY_W'(w);
         end
      end
      // all ways valid: evict the oldest
      if (!found_inv)
         for (int w = 0; w < WAYS; w++)
            if (age[in_idx][w] == WAY_W'(WAYS-1)) vic_way = WAY_W'(w);
   end

   assign accept     = req_valid && req_ready;
   assign hit_acc    = accept && hit;
   assign fill_acc   = (state == S_FILL) && fill_valid;
   assign hit_line   = data_mem[in_idx][hit_way];
   assign hit_merged = merge(hit_line, req_data, req_mask);
   assign fill_line  = merge(fill_data, l_data, l_w ? l_mask : '0);

   assign lru_en  = hit_acc || fill_acc;
   assign lru_set = fill_acc ? l_idx : in_idx;
   assign lru_way = fill_acc ? l_way : hit_way;

   // tags and data survive reset and invalidate; only valid bits qualify them
   always_ff @(posedge clk) begin
      if (hit_acc && req_w) data_mem[in_idx][hit_way] <= hit_merged;
      if (fill_acc) begin
         data_mem[l_idx][l_way] <= fill_line;
         tag_mem[l_idx][l_way]  <= l_tag;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
               age[s][w] <= WAY_W'(w);
      end else if (lru_en) begin
         for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == lru_way)
               age[lru_set][w] <= '0;
            else if (age[lru_set][w] < age[lru_set][lru_way])
               age[lru_set][w] <= age[lru_set][w] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         valid       <= '0;
         dirty       <= '0;
         inv_pend    <= 1'b0;
         hit_cnt     <= '0;
         miss_cnt    <= '0;
         resp_valid  <= 1'b0;
         resp_data   <= '0;
         resp_id     <= '0;
         resp_hit    <= 1'b0;
         mem_wb_addr <= '0;
         mem_wb_data <= '0;
         mem_rd_addr <= '0;
         l_idx       <= '0;
         l_tag       <= '0;
         l_way       <= '0;
         l_w         <= 1'b0;
         l_data      <= '0;
         l_mask      <= '0;
         l_id        <= '0;
      end else begin
         resp_valid <= 1'b0;
         if (inv_all && state != S_IDLE) inv_pend <= 1'b1;
         case (state)
            S_IDLE: begin
               if (inv_all || inv_pend) begin
                  valid    <= '0;
                  dirty    <= '0;
                  inv_pend <= 1'b0;
               end else if (req_valid) begin
                  l_idx  <= in_idx;
                  l_tag  <= in_tag;
                  l_w    <= req_w;
                  l_data <= req_data;
                  l_mask <= req_mask;
                  l_id   <= req_id;
                  if (hit) begin
                     resp_valid <= 1'b1;
                     resp_hit   <= 1'b1;
                     resp_id    <= req_id;
                     resp_data  <= req_w ? hit_merged : hit_line;
                     if (req_w) dirty[in_idx][hit_way] <= 1'b1;
                     hit_cnt <= hit_cnt + 16'd1;
                  end else begin
                     miss_cnt    <= miss_cnt + 16'd1;
                     l_way       <= vic_way;
                     mem_rd_addr <= {in_tag, in_idx, {OFF_W{1'b0}}};
                     if (valid[in_idx][vic_way] && dirty[in_idx][vic_way]) begin
                        mem_wb_addr <= {tag_mem[in_idx][vic_way], in_idx, {OFF_W{1'b0}}};
                        mem_wb_data <= data_mem[in_idx][vic_way];
                        state       <= S_WB;
                     end else begin
                        state <= S_RD;
                     end
                  end
               end
            end
            S_WB:   if (mem_wb_ready) state <= S_RD;
            S_RD:   if (mem_rd_ready) state <= S_FILL;
            S_FILL: begin
               if (fill_valid) begin
                  valid[l_idx][l_way] <= 1'b1;
                  dirty[l_idx][l_way] <= l_w;
                  resp_valid <= 1'b1;
                  resp_hit   <= 1'b0;
                  resp_id    <= l_id;
                  resp_data  <= fill_line;
                  state      <= S_RESP;
               end
            end
            S_RESP: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_bank_param.sv
// Directed bench for cache_bank_param at default geometry: hits, misses, dirty
// eviction, handshake stalls, deferred invalidate and reset during writeback.
module tb_cache_bank_param;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [14:0]  req_pAddress = '0;
   logic         req_w = 1'b0;
   logic [127:0] req_data = '0;
   logic [15:0]  req_mask = '0;
   logic [6:0]   req_id = '0;
   logic         inv_all = 1'b0;
   logic         resp_valid;
   logic [127:0] resp_data;
   logic [6:0]   resp_id;
   logic         resp_hit;
   logic         mem_wb_valid;
   logic         mem_wb_ready = 1'b1;
   logic [14:0]  mem_wb_addr;
   logic [127:0] mem_wb_data;
   logic         mem_rd_valid;
   logic         mem_rd_ready = 1'b1;
   logic [14:0]  mem_rd_addr;
   logic         fill_valid = 1'b1;
   logic [127:0] fill_data = '0;
   logic [15:0]  hit_cnt;
   logic [15:0]  miss_cnt;

   int n_chk = 0;
   int n_pass = 0;

   logic [127:0] r_data;
   logic         r_hit;
   logic [6:0]   r_id;
   int           lat;
   logic         saw_wb;
   logic [14:0]  wb_a;
   logic [127:0] wb_d;
   logic [14:0]  rd_a;

   cache_bank_param dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_pAddress(req_pAddress),
      .req_w(req_w), .req_data(req_data), .req_mask(req_mask), .req_id(req_id),
      .inv_all(inv_all),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_id(resp_id), .resp_hit(resp_hit),
      .mem_wb_valid(mem_wb_valid), .mem_wb_ready(mem_wb_ready),
      .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data),
      .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
      .fill_valid(fill_valid), .fill_data(fill_data),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // memory image: byte b of the line at tag t is b + 16*(t-1)
   function automatic logic [127:0] fpat(input logic [14:0] a);
      logic [127:0] r;
      int t;
      t = int'(a >> 6);
      for (int b = 0; b < 16; b++) r[8*b +: 8] = 8'(b + 16*t - 16);
      return r;
   endfunction

   task automatic send(input logic [14:0] a, input logic w, input logic [127:0] d,
                       input logic [15:0] m, input logic [6:0] id);
      int n;
      @(negedge clk);
      req_pAddress = a; req_w = w; req_data = d; req_mask = m; req_id = id;
      fill_data = fpat(a);
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check("accept_timeout", 1'b0, 1'b1);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_resp();
      lat = 0; saw_wb = 1'b0; wb_a = '1; wb_d = '0; rd_a = '1;
      r_data = '0; r_hit = 1'bx; r_id = '0;
      while (lat < 30) begin
         @(negedge clk);
         lat++;
         if (mem_wb_valid) begin saw_wb = 1'b1; wb_a = mem_wb_addr; wb_d = mem_wb_data; end
         if (mem_rd_valid) rd_a = mem_rd_addr;
         if (resp_valid) begin
            r_data = resp_data; r_hit = resp_hit; r_id = resp_id;
            break;
         end
      end
      if (!resp_valid) check("resp_timeout", 1'b0, 1'b1);
   endtask

   task automatic req(input logic [14:0] a, input logic w, input logic [127:0] d,
                      input logic [15:0] m, input logic [6:0] id);
      send(a, w, d, m, id);
      wait_resp();
   endtask

   initial begin
      #12;
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_rd_valid", mem_rd_valid, 1'b0);
      check("rst_wb_valid", mem_wb_valid, 1'b0);
      check("rst_cnts", {hit_cnt, miss_cnt}, 32'h0);
      @(negedge clk) rst = 1'b1;

      // clean miss, then hit on the same line
      req(15'h0040, 1'b0, '0, '0, 7'd1);
      check("miss_rd_addr", rd_a, 15'h0040);
      check("miss_hit", r_hit, 1'b0);
      check("miss_data", r_data, 128'h0F0E0D0C0B0A09080706050403020100);
      check("miss_id", r_id, 7'd1);
      check("miss_cnt1", miss_cnt, 16'd1);
      check("miss_lat", lat, 3);
      req(15'h0040, 1'b0, '0, '0, 7'd2);
      check("hit_lat", lat, 1);
      check("hit_hit", r_hit, 1'b1);
      check("hit_cnt1", hit_cnt, 16'd1);

      // write hit merges byte 0
      req(15'h0040, 1'b1, 128'hAA, 16'h0001, 7'd3);
      check("wr_hit_data", r_data, 128'h0F0E0D0C0B0A090807060504030201AA);
      check("wr_hit_hit", r_hit, 1'b1);

      // fill set 0, dirty 0x0080, touch the others, evict 0x0080
      req(15'h0080, 1'b0, '0, '0, 7'd4);
      req(15'h00C0, 1'b0, '0, '0, 7'd5);
      req(15'h0100, 1'b0, '0, '0, 7'd6);
      check("fill4_hit", r_hit, 1'b0);
      req(15'h0080, 1'b1, 128'h77000000000000000000000000000055, 16'h8001, 7'd7);
      check("wr80_data", r_data, 128'h771E1D1C1B1A19181716151413121155);
      req(15'h0040, 1'b0, '0, '0, 7'd8);
      check("rd40_data", r_data, 128'h0F0E0D0C0B0A090807060504030201AA);
      req(15'h00C0, 1'b0, '0, '0, 7'd9);
      req(15'h0100, 1'b0, '0, '0, 7'd10);
      check("rd100_hit", r_hit, 1'b1);
      req(15'h0140, 1'b0, '0, '0, 7'd11);
      check("evict_wb_seen", saw_wb, 1'b1);
      check("evict_wb_addr", wb_a, 15'h0080);
      check("evict_wb_data", wb_d, 128'h771E1D1C1B1A19181716151413121155);
      check("evict_rd_addr", rd_a, 15'h0140);
      check("evict_lat", lat, 4);
      check("evict_data", r_data, 128'h4F4E4D4C4B4A49484746454443424140);

      // next victim is dirty 0x0040; stall the writeback then reset
      mem_wb_ready = 1'b0;
      send(15'h0180, 1'b0, '0, '0, 7'd12);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("wb_hold_valid", mem_wb_valid, 1'b1);
         check("wb_hold_addr", mem_wb_addr, 15'h0040);
         check("wb_hold_data", mem_wb_data, 128'h0F0E0D0C0B0A090807060504030201AA);
      end
      #2 rst = 1'b0;
      #1;
      check("arst_req_ready", req_ready, 1'b1);
      check("arst_wb_valid", mem_wb_valid, 1'b0);
      check("arst_wb_addr", mem_wb_addr, 15'h0);
      check("arst_rd_valid", mem_rd_valid, 1'b0);
      check("arst_cnts", {hit_cnt, miss_cnt}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      mem_wb_ready = 1'b1;
      req(15'h0040, 1'b0, '0, '0, 7'd13);
      check("post_rst_hit", r_hit, 1'b0);
      check("post_rst_wb", saw_wb, 1'b0);
      check("post_rst_miss", miss_cnt, 16'd1);

      // read handshake stall, fill stall, invalidate pulsed during FILL
      mem_rd_ready = 1'b0;
      send(15'h0010, 1'b0, '0, '0, 7'd14);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rd_hold_valid", mem_rd_valid, 1'b1);
         check("rd_hold_addr", mem_rd_addr, 15'h0010);
      end
      mem_rd_ready = 1'b1;
      fill_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         inv_all = (i == 1);
         check("fill_wait_resp", resp_valid, 1'b0);
         check("fill_wait_ready", req_ready, 1'b0);
      end
      @(negedge clk);
      inv_all = 1'b0;
      fill_valid = 1'b1;
      wait_resp();
      check("stall_hit", r_hit, 1'b0);
      check("stall_data", r_data, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
      check("stall_id", r_id, 7'd14);
      req(15'h0010, 1'b0, '0, '0, 7'd15);
      check("inv_miss_hit", r_hit, 1'b0);
      check("inv_rd_addr", rd_a, 15'h0010);
      check("inv_miss_cnt", miss_cnt, 16'd3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cache_bank_param.md
# cache_bank_param

Parametrised, write-back, write-allocate set-associative cache bank, successor to the fixed 4-way/16-byte bank in processor/M/cache. Accepts one line-granular request at a time from the address queue side. Resolves hits in one cycle and handles misses with an internal FSM: dirty-victim writeback, line read request, then fill. Adds configurable geometry, true-LRU replacement, a bulk invalidate and hit/miss counters.

## Interface
Parameters:
- WAYS, 4, associativity; power of 2, ≥2
- SETS, 4, sets per bank; power of 2, ≥2
- LINE_BYTES, 16, bytes per line; power of 2, ≥4
- PADDR_W, 15, physical address width
- ID_W, 7, request tag width (PTC id)
- Derived: OFF_W=log2(LINE_BYTES), IDX_W=log2(SETS), TAG_W=PADDR_W-OFF_W-IDX_W; offset=pAddr[OFF_W-1:0], index=pAddr[OFF_W+IDX_W-1:OFF_W], tag=pAddr[PADDR_W-1:OFF_W+IDX_W]

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  bank accepts this cycle
- req_pAddress  in  PADDR_W  request address; offset ignored
- req_w  in  1  1=write, 0=read
- req_data  in  8*LINE_BYTES  write data
- req_mask  in  LINE_BYTES  byte enables for writes
- req_id  in  ID_W  request tag
- inv_all  in  1  pulse; invalidate every line
- resp_valid  out  1  one-cycle response strobe; no backpressure
- resp_data  out  8*LINE_BYTES  line after any write merge
- resp_id  out  ID_W  req_id of the answered request
- resp_hit  out  1  1=hit, 0=serviced by fill
- mem_wb_valid / mem_wb_ready  out/in  1  writeback handshake
- mem_wb_addr  out  PADDR_W  victim line address, offset zero
- mem_wb_data  out  8*LINE_BYTES  victim line
- mem_rd_valid / mem_rd_ready  out/in  1  line read handshake
- mem_rd_addr  out  PADDR_W  missing line address, offset zero
- fill_valid  in  1  fill data present; consumed only in FILL
- fill_data  in  8*LINE_BYTES  fill line
- hit_cnt, miss_cnt  out  16  wrapping event counters

## Operation
- State per way/set: valid, dirty, tag, data and a log2(WAYS)-bit LRU age.
- FSM states: IDLE, WB, RD, FILL, RESP.
- req_ready = (state==IDLE) & !inv_all & !inv_pend.
- Accept when req_valid & req_ready. Latch the address, w, data, mask and id.
- Hit (valid & tag match): read returns the line. Write merges req_data under req_mask, sets dirty and returns the merged line. LRU updates, hit_cnt increments, resp_hit=1. State stays IDLE.
- Miss: miss_cnt increments. Victim is the lowest-indexed invalid way; if none, the way with age WAYS-1.
  - Victim valid & dirty → WB.
  - Otherwise → RD.
- WB: hold mem_wb_valid with stable addr/data until mem_wb_ready, then → RD.
- RD: hold mem_rd_valid/addr until mem_rd_ready, then → FILL.
- FILL: on fill_valid, write the victim way. tag=new, valid=1, dirty=req_w. Write data is merged over fill_data under mask. LRU updates. → RESP.
- RESP: resp_valid=1, resp_hit=0, resp_data = installed line. → IDLE.
- LRU update on access to way k with old age a: age[k]←0; every way with age<a increments. Reset ages: way i = i.
- inv_all:
  - In IDLE: clears all valid and dirty bits next edge with no writeback. Tags, data and LRU are kept.
  - Outside IDLE: sets inv_pend. The pending invalidate is applied on the first IDLE cycle, before any accept.
  - inv_all together with req_valid in IDLE: the request is not accepted.
- Reset (any state, asynchronous): state=IDLE and all valid/dirty bits clear. LRU ages set to i. inv_pend=0 and counters=0. All outputs 0 except req_ready=1. An in-flight miss is abandoned.

## Timing
- Hit: accept at edge T, resp_valid high T→T+1 (registered outputs).
- Clean miss: mem_rd_valid from T. Fill accepted at edge F, resp_valid during cycle after F.
- Dirty miss: mem_wb_valid from T. mem_rd_valid starts the cycle after the wb handshake.
- Minimum clean-miss latency with ready/fill_valid tied high: accept→resp 3 cycles.
- Next request is accepted no earlier than the cycle after resp_valid on misses.
- Handshake outputs never drop or change while waiting for ready.
- fill_valid outside FILL is ignored.

## Test plan
Defaults: offset [3:0], index [5:4], tag [14:6].
- Reset, read 0x0040 → mem_rd_addr=0x0040. fill_data=0x0F0E..00 → resp_hit=0, resp_data equals fill, miss_cnt=1. Re-read → resp at T+1, resp_hit=1, hit_cnt=1.
- Write hit 0x0040, mask=0x0001, data byte0=0xAA → resp_data byte0=0xAA, bytes 1–15 unchanged. Line becomes dirty.
- Fill set 0 with 0x0040, 0x0080, 0x00C0, 0x0100, write 0x0080, re-read 0x0040, 0x00C0, 0x0100, then read 0x0140 → victim is the 0x0080 way. mem_wb_addr=0x0080 carries the written data, then mem_rd_addr=0x0140.
- Hold mem_rd_ready=0 for 5 cycles → mem_rd_valid/addr stable. Hold fill_valid=0 for 3 cycles in FILL → no resp and req_ready=0.
- Pulse inv_all during FILL → the miss completes normally. The following read of the same line misses, with miss_cnt incremented.
- Assert rst during WB → all outputs at reset values immediately, req_ready=1. Next read of the former line misses.
